// File: rtl/adc_resp_pkg.sv
// Shared constants, frame layout and register reset table for adc_serial_responder.
package adc_resp_pkg;

  localparam logic [11:0] FRAME_HEADER = 12'h001;
  localparam int          FRAME_BITS   = 32;
  localparam logic [3:0]  CFG_ADDR     = 4'h1;
  localparam int          CAL_BIT      = 15;

  localparam logic [1:0] SS_IDLE  = 2'd0;
  localparam logic [1:0] SS_SHIFT = 2'd1;
  localparam logic [1:0] SS_WAIT  = 2'd2;

  localparam logic [1:0] CS_IDLE = 2'd0;
  localparam logic [1:0] CS_DLY  = 2'd1;
  localparam logic [1:0] CS_RUN  = 2'd2;

  typedef struct packed {
    logic [11:0] header;
    logic [3:0]  addr;
    logic [15:0] data;
  } frame_t;

  function automatic logic [15:0] reg_reset_value(input logic [3:0] addr);
    logic [15:0] value;
    case (addr)
      4'h2:    value = 16'h0A5A;
      4'h3:    value = 16'h1F00;
      4'h4:    value = 16'h0010;
      4'h5:    value = 16'h5A5A;
      4'h6:    value = 16'h7FFF;
      4'hF:    value = 16'hC0DE;
      default: value = 16'h0000;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/adc_resp_sync.sv
// Two-flop synchronizer with registered rise/fall pulses: 3-cycle pin-to-pulse latency.
module adc_resp_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic s1_reg, s2_reg, s3_reg;
  logic rise_reg, fall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
      s3_reg   <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      s1_reg   <= din;
      s2_reg   <= s1_reg;
      s3_reg   <= s2_reg;
      rise_reg <= s2_reg & ~s3_reg;
      fall_reg <= ~s2_reg & s3_reg;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;

endmodule

// File: rtl/adc_serial_responder.sv
// Far-end model of the ADC three-wire control port and calibration handshake.
// Calibration logic is built only when ADC_RESP_CAL_EN is defined.
module adc_serial_responder
  import adc_resp_pkg::*;
#(
  parameter int CAL_DELAY  = 4,
  parameter int CAL_LENGTH = 10
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InSclk,
  input  logic        InSdata,
  input  logic        InSelect,
  input  logic        InPD,
  input  logic        InCal,
  output logic        OutCalRunning,
  output logic        OutRegWrite,
  output logic [3:0]  OutRegAddr,
  output logic [15:0] OutRegData,
  output logic        OutFrameError,
  input  logic [3:0]  InRdAddr,
  output logic [15:0] OutRdData
);

  logic sclk_rise, sclk_fall_unused;
  logic sel_rise, sel_fall;

  adc_resp_sync u_sync_sclk (
    .clk   (Clock),
    .rst_n (Reset),
    .din   (InSclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall_unused)
  );

  adc_resp_sync u_sync_sel (
    .clk   (Clock),
    .rst_n (Reset),
    .din   (InSelect),
    .rise  (sel_rise),
    .fall  (sel_fall)
  );

  // Sdata is delayed to stay aligned with the value Sclk had when its edge was seen.
  logic sdata_s1_reg, sdata_s2_reg, sdata_s3_reg;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sdata_s1_reg <= 1'b0;
      sdata_s2_reg <= 1'b0;
      sdata_s3_reg <= 1'b0;
    end else begin
      sdata_s1_reg <= InSdata;
      sdata_s2_reg <= sdata_s1_reg;
      sdata_s3_reg <= sdata_s2_reg;
    end
  end

  logic [1:0]  ser_state_reg, ser_state_next;
  logic [30:0] shift_reg, shift_next;
  logic [4:0]  count_reg, count_next;
  frame_t      frame_word;
  logic        header_ok;
  logic        commit;
  logic        frame_err;

  assign frame_word = frame_t'({shift_reg, sdata_s3_reg});
  assign header_ok  = (frame_word.header == FRAME_HEADER);

  // An Sclk edge in the same cycle as a Select rise is consumed first.
  always_comb begin
    ser_state_next = ser_state_reg;
    shift_next     = shift_reg;
    count_next     = count_reg;
    commit         = 1'b0;
    frame_err      = 1'b0;
    case (ser_state_reg)
      SS_IDLE: begin
        if (sel_fall) begin
          shift_next     = '0;
          count_next     = '0;
          ser_state_next = SS_SHIFT;
        end
      end
      SS_SHIFT: begin
        if (sclk_rise) begin
          shift_next = frame_word[30:0];
          count_next = count_reg + 5'd1;
          if (count_reg == 5'(FRAME_BITS - 1)) begin
            commit         = header_ok;
            frame_err      = ~header_ok;
            ser_state_next = sel_rise ? SS_IDLE : SS_WAIT;
          end else if (sel_rise) begin
            frame_err      = 1'b1;
            ser_state_next = SS_IDLE;
          end
        end else if (sel_rise) begin
          frame_err      = 1'b1;
          ser_state_next = SS_IDLE;
        end
      end
      SS_WAIT: begin
        if (sel_rise) begin
          ser_state_next = SS_IDLE;
        end
      end
      default: ser_state_next = SS_IDLE;
    endcase
  end

  logic        reg_write_reg;
  logic        frame_error_reg;
  logic [3:0]  reg_addr_reg;
  logic [15:0] reg_data_reg;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ser_state_reg   <= SS_IDLE;
      shift_reg       <= '0;
      count_reg       <= '0;
      reg_write_reg   <= 1'b0;
      frame_error_reg <= 1'b0;
      reg_addr_reg    <= '0;
      reg_data_reg    <= '0;
    end else begin
      ser_state_reg   <= ser_state_next;
      shift_reg       <= shift_next;
      count_reg       <= count_next;
      reg_write_reg   <= commit;
      frame_error_reg <= frame_err;
      if (commit) begin
        reg_addr_reg <= frame_word.addr;
        reg_data_reg <= frame_word.data;
      end
    end
  end

  logic [15:0] regfile [16];
  logic [15:0] rd_data_reg;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 16; i++) begin
        regfile[i] <= reg_reset_value(4'(i));
      end
    end else if (commit) begin
      regfile[frame_word.addr] <= frame_word.data;
    end
  end

  // Read samples the array before this cycle's write lands, so a collision returns old data.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= regfile[InRdAddr];
    end
  end

  assign OutRegWrite   = reg_write_reg;
  assign OutFrameError = frame_error_reg;
  assign OutRegAddr    = reg_addr_reg;
  assign OutRegData    = reg_data_reg;
  assign OutRdData     = rd_data_reg;

`ifdef ADC_RESP_CAL_EN
  localparam int CAL_MAX = (CAL_DELAY > CAL_LENGTH) ? CAL_DELAY : CAL_LENGTH;
  localparam int CNT_W   = (CAL_MAX < 2) ? 1 : $clog2(CAL_MAX + 1);

  logic cal_rise, cal_fall_unused;

  adc_resp_sync u_sync_cal (
    .clk   (Clock),
    .rst_n (Reset),
    .din   (InCal),
    .rise  (cal_rise),
    .fall  (cal_fall_unused)
  );

  logic [1:0]       cal_state_reg, cal_state_next;
  logic [CNT_W-1:0] cal_cnt_reg, cal_cnt_next;
  logic             cal_running_reg;
  logic             cfg_cal;

  assign cfg_cal = commit && (frame_word.addr == CFG_ADDR) && frame_word.data[CAL_BIT];

  // Power-down outranks every other transition.
  always_comb begin
    cal_state_next = cal_state_reg;
    cal_cnt_next   = cal_cnt_reg;
    if (InPD) begin
      cal_state_next = CS_IDLE;
      cal_cnt_next   = '0;
    end else begin
      case (cal_state_reg)
        CS_IDLE: begin
          if (cal_rise || cfg_cal) begin
            cal_state_next = CS_DLY;
            cal_cnt_next   = '0;
          end
        end
        CS_DLY: begin
          if (int'(cal_cnt_reg) + 1 >= CAL_DELAY) begin
            cal_state_next = CS_RUN;
            cal_cnt_next   = '0;
          end else begin
            cal_cnt_next = cal_cnt_reg + CNT_W'(1);
          end
        end
        CS_RUN: begin
          if (int'(cal_cnt_reg) + 1 >= CAL_LENGTH) begin
            cal_state_next = CS_IDLE;
            cal_cnt_next   = '0;
          end else begin
            cal_cnt_next = cal_cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          cal_state_next = CS_IDLE;
          cal_cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cal_state_reg   <= CS_IDLE;
      cal_cnt_reg     <= '0;
      cal_running_reg <= 1'b0;
    end else begin
      cal_state_reg   <= cal_state_next;
      cal_cnt_reg     <= cal_cnt_next;
      cal_running_reg <= (cal_state_next == CS_RUN);
    end
  end

  assign OutCalRunning = cal_running_reg;
`else
  logic unused_cal;
  assign unused_cal = ^{InCal, InPD, CAL_DELAY != 0, CAL_LENGTH != 0,
                        CFG_ADDR, CAL_BIT != 0, CS_IDLE, CS_DLY, CS_RUN};
  assign OutCalRunning = 1'b0;
`endif

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder with a write/error scoreboard.
module tb_adc_serial_responder;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        InSclk, InSdata, InSelect, InPD, InCal;
  logic        OutCalRunning, OutRegWrite, OutFrameError;
  logic [3:0]  OutRegAddr, InRdAddr;
  logic [15:0] OutRegData, OutRdData;

  adc_serial_responder #(.CAL_DELAY(4), .CAL_LENGTH(10)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .InSclk        (InSclk),
    .InSdata       (InSdata),
    .InSelect      (InSelect),
    .InPD          (InPD),
    .InCal         (InCal),
    .OutCalRunning (OutCalRunning),
    .OutRegWrite   (OutRegWrite),
    .OutRegAddr    (OutRegAddr),
    .OutRegData    (OutRegData),
    .OutFrameError (OutFrameError),
    .InRdAddr      (InRdAddr),
    .OutRdData     (OutRdData)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        err;
    logic [3:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   sclk_cyc = 0;
  int   wr_cyc = 0;
  int   run_len = 0;
  int   last_len = 0;
  int   runs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge Clock) cyc++;

  // Scoreboard: every write or error pulse must match the oldest expectation.
  always @(negedge Clock) begin
    exp_t e;
    if (OutRegWrite || OutFrameError) begin
      if (OutRegWrite) wr_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'd0, OutRegWrite, OutFrameError}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", {30'd0, OutRegWrite, OutFrameError}, e.err ? 32'd1 : 32'd2);
        if (!e.err) begin
          check("wr_addr", {28'd0, OutRegAddr}, {28'd0, e.addr});
          check("wr_data", {16'd0, OutRegData}, {16'd0, e.data});
        end
        $display("txn %s addr=%h data=%h", e.err ? "error" : "write", OutRegAddr, OutRegData);
      end
    end
  end

  always @(negedge Clock) begin
    if (OutCalRunning) begin
      run_len = run_len + 1;
    end else if (run_len != 0) begin
      last_len = run_len;
      runs = runs + 1;
      run_len = 0;
    end
  end

  task automatic expect_write(input logic [3:0] a, input logic [15:0] d);
    sb.push_back('{err: 1'b0, addr: a, data: d});
  endtask

  task automatic expect_error();
    sb.push_back('{err: 1'b1, addr: 4'h0, data: 16'h0000});
  endtask

  task automatic send_frame(input logic [31:0] frame, input int nbits,
                            input bit raise_with_last, input bit finish);
    @(negedge Clock);
    InSelect = 1'b0;
    repeat (4) @(negedge Clock);
    for (int i = 0; i < nbits; i++) begin
      InSdata = frame[31-i];
      InSclk  = 1'b0;
      repeat (4) @(negedge Clock);
      InSclk = 1'b1;
      sclk_cyc = cyc;
      if (raise_with_last && i == nbits - 1) InSelect = 1'b1;
      repeat (4) @(negedge Clock);
    end
    if (finish) begin
      InSclk = 1'b0;
      repeat (4) @(negedge Clock);
      InSelect = 1'b1;
      repeat (6) @(negedge Clock);
    end
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
    @(negedge Clock);
    InRdAddr = a;
    @(negedge Clock);
    check(tag, {16'd0, OutRdData}, {16'd0, exp});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr"},   {31'd0, OutRegWrite},   32'd0);
    check({tag, "_err"},  {31'd0, OutFrameError}, 32'd0);
    check({tag, "_addr"}, {28'd0, OutRegAddr},    32'd0);
    check({tag, "_data"}, {16'd0, OutRegData},    32'd0);
    check({tag, "_rd"},   {16'd0, OutRdData},     32'd0);
    check({tag, "_cal"},  {31'd0, OutCalRunning}, 32'd0);
  endtask

  // Cal rise driven at k=0; running expected on samples 8..17 unless powered down at pd_at.
  task automatic cal_window(input string tag, input int pd_at);
    logic exp_run;
    @(negedge Clock);
    InCal = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge Clock);
      exp_run = (k >= 8 && k <= 17 && (pd_at == 0 || k <= pd_at));
      check(tag, {31'd0, OutCalRunning}, {31'd0, exp_run});
      if (k == 9)  InCal = 1'b0;
      if (k == 13) InCal = 1'b1;
      if (pd_at != 0 && k == pd_at) InPD = 1'b1;
    end
    InCal = 1'b0;
    InPD  = 1'b0;
    repeat (6) @(negedge Clock);
  endtask

  initial begin
    Reset    = 1'b0;
    InSclk   = 1'b0;
    InSdata  = 1'b0;
    InSelect = 1'b1;
    InPD     = 1'b0;
    InCal    = 1'b0;
    InRdAddr = 4'h0;
    repeat (3) @(negedge Clock);
    check_all_zero("reset");
    Reset = 1'b1;
    repeat (5) @(negedge Clock);

    read_check("rst_val_3", 4'h3, 16'h1F00);
    read_check("rst_val_5", 4'h5, 16'h5A5A);

    expect_write(4'h1, 16'hABCD);
    send_frame(32'h0011_ABCD, 32, 1'b0, 1'b1);
    check("wr_latency", wr_cyc - sclk_cyc, 32'd4);
    read_check("rd_addr1", 4'h1, 16'hABCD);
    repeat (12) @(negedge Clock);
`ifdef ADC_RESP_CAL_EN
    check("cfg_cal_runs", runs, 32'd1);
    check("cfg_cal_len", last_len, 32'd10);
`else
    check("cfg_cal_off", runs, 32'd0);
`endif

    expect_error();
    send_frame(32'h0023_1234, 32, 1'b0, 1'b1);
    read_check("bad_hdr_reg3", 4'h3, 16'h1F00);
    check("bad_hdr_addr", {28'd0, OutRegAddr}, 32'h1);
    check("bad_hdr_data", {16'd0, OutRegData}, 32'hABCD);

    expect_error();
    send_frame(32'h0015_00FF, 20, 1'b0, 1'b1);
    expect_write(4'h5, 16'h00FF);
    send_frame(32'h0015_00FF, 32, 1'b0, 1'b1);
    read_check("rd_addr5", 4'h5, 16'h00FF);

    expect_write(4'h9, 16'h1357);
    send_frame(32'h0019_1357, 32, 1'b1, 1'b1);
    read_check("same_cyc_rd9", 4'h9, 16'h1357);
    expect_write(4'hA, 16'h2468);
    send_frame(32'h001A_2468, 32, 1'b0, 1'b1);
    read_check("after_same_rdA", 4'hA, 16'h2468);

`ifdef ADC_RESP_CAL_EN
    cal_window("cal_window", 0);
    cal_window("cal_pd", 12);
    cal_window("cal_restart", 0);
`else
    InCal = 1'b1;
    repeat (20) @(negedge Clock);
    InCal = 1'b0;
    repeat (5) @(negedge Clock);
    check("cal_disabled", runs, 32'd0);
`endif

    send_frame(32'h0017_BEEF, 16, 1'b0, 1'b0);
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    check_all_zero("mid_reset");
    InSclk   = 1'b0;
    InSelect = 1'b1;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (6) @(negedge Clock);
    read_check("post_rst_reg5", 4'h5, 16'h5A5A);
    read_check("post_rst_reg1", 4'h1, 16'h0000);
    expect_write(4'h7, 16'hBEEF);
    send_frame(32'h0017_BEEF, 32, 1'b0, 1'b1);
    read_check("post_rst_rd7", 4'h7, 16'hBEEF);

    repeat (10) @(negedge Clock);
    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
